dcache_wb: RTL and testbench
============================

DCACHE_WB -- requirements
Module: dcache_wb

Interface
REQ-001 SHALL have parameter WORD_W, default 32, data word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-003 SHALL have parameter NUM_LINES, default 4, number of direct-mapped lines (power of two, >=2).
REQ-004 SHALL have parameter WORDS_PER_LINE, default 4, words per line (power of two, >=2); LINE_W = WORD_W*WORDS_PER_LINE.
REQ-005 SHALL have ports:
- clk  in  1  clock; single clock domain, rising edge.
- rst  in  1  synchronous, active-high reset.
- A  in  ADDR_W  byte address; [1:0] ignored, then word offset, index, tag (LSB to MSB).
- ReadEnable  in  1  load request.
- WriteEnable  in  1  store request.
- WData  in  WORD_W  store data.
- MemLine  in  LINE_W  fill line from memory.
- MemReady  in  1  memory completes current read/write.
- Value  out  WORD_W  load data.
- AMem  out  ADDR_W  line-aligned memory address.
- MemRead  out  1  fill request.
- MemWrite  out  1  writeback request.
- MemWLine  out  LINE_W  writeback line.
- CacheStall  out  1  pipeline must hold request.
- HitCount  out  32  hit counter.
- MissCount  out  32  miss counter.

Function
REQ-006 SHALL be direct-mapped, write-back, write-allocate, with per-line valid, dirty, tag.
REQ-007 SHALL use FSM states IDLE, WRITEBACK, FILL.
REQ-008 SHALL define an access as (ReadEnable|WriteEnable) in IDLE; WriteEnable has priority when both set.
REQ-009 Hit = valid[index] && tag[index]==A tag.
REQ-010 Read hit: Value SHALL be selected word combinationally, same cycle; CacheStall=0.
REQ-011 Write hit: selected word SHALL be replaced by WData and dirty set at the next rising edge; CacheStall=0.
REQ-012 Miss: CacheStall SHALL be 1 combinationally in the same cycle; next state WRITEBACK if victim valid&&dirty, else FILL.
REQ-013 WRITEBACK: MemWrite=1, AMem={victim tag,index,zero offset}, MemWLine=victim line; on MemReady clear dirty, go FILL.
REQ-014 FILL: MemRead=1, AMem={A tag,index,zero offset}; on MemReady write MemLine, tag, valid=1, dirty=0, go IDLE.
REQ-015 CacheStall SHALL be 1 in WRITEBACK and FILL; the held request is re-evaluated in IDLE the cycle after fill and hits.
REQ-016 MemRead/MemWrite SHALL never be asserted together; both 0 in IDLE; MemReady ignored in IDLE.
REQ-017 A, ReadEnable, WriteEnable, WData SHALL be required stable by the requester while CacheStall=1.
REQ-018 Value SHALL be 0 when no read hit in IDLE.

Reset
REQ-019 On rst at a rising edge: state IDLE, all valid and dirty 0, counters 0.
REQ-020 Outputs after reset: MemRead=0, MemWrite=0, CacheStall=0 unless a new access misses, Value=0, AMem=0.
REQ-021 Reset mid-WRITEBACK/FILL SHALL abandon the transaction; dirty data is lost; no array write occurs.

Configuration
REQ-022 Macro DCACHE_PERF_CNT_EN defined: HitCount increments once per hit access cycle in IDLE, MissCount once per IDLE->WRITEBACK/FILL transition; both wrap at 2^32.
REQ-023 Macro undefined: HitCount and MissCount tied to 0, no counter registers.

Verification
REQ-024 Reset, read A=0x10 -> CacheStall=1, FILL, MemRead=1, AMem=0x10; MemReady with MemLine word0=0xAAAA0001 -> next cycle Value=0xAAAA0001, CacheStall=0.
REQ-025 Write hit A=0x14 WData=0xDEADBEEF, then read 0x14 -> Value=0xDEADBEEF, no MemRead/MemWrite.
REQ-026 Dirty line at index 1, read A=0x110 (same index, new tag) -> WRITEBACK with AMem=0x10, MemWLine containing 0xDEADBEEF, then FILL AMem=0x110.
REQ-027 rst asserted in FILL before MemReady -> next cycle MemRead=0, state IDLE, read 0x10 misses again.
REQ-028 With DCACHE_PERF_CNT_EN: 1 miss then 3 read hits -> MissCount=1, HitCount=4 (includes replayed access); without macro both 0.

Source files
------------

// File: rtl/dcache_wb.sv
// Direct-mapped, write-back, write-allocate data cache with an IDLE/WRITEBACK/FILL miss FSM.
// Define DCACHE_PERF_CNT_EN to build the hit/miss counters; otherwise both counters read 0.
module dcache_wb #(
    parameter int WORD_W         = 32,
    parameter int ADDR_W         = 32,
    parameter int NUM_LINES      = 4,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [ADDR_W-1:0]                A,
    input  logic                             ReadEnable,
    input  logic                             WriteEnable,
    input  logic [WORD_W-1:0]                WData,
    input  logic [WORD_W*WORDS_PER_LINE-1:0] MemLine,
    input  logic                             MemReady,
    output logic [WORD_W-1:0]                Value,
    output logic [ADDR_W-1:0]                AMem,
    output logic                             MemRead,
    output logic                             MemWrite,
    output logic [WORD_W*WORDS_PER_LINE-1:0] MemWLine,
    output logic                             CacheStall,
    output logic [31:0]                      HitCount,
    output logic [31:0]                      MissCount
);
    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int LOW_W = OFF_W + 2;
    localparam int TAG_W = ADDR_W - LOW_W - IDX_W;

    typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_e;
    typedef logic [WORDS_PER_LINE-1:0][WORD_W-1:0] line_t;

    state_e               state_q, state_d;
    logic [NUM_LINES-1:0] valid_q, dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    line_t                data_q [NUM_LINES];

    logic [OFF_W-1:0] a_off;
    logic [IDX_W-1:0] a_idx;
    logic [TAG_W-1:0] a_tag;
    logic             unused_byte_bits;
    logic             hit, rd_hit, wr_hit, miss, wb_done, fill_done;

    assign a_off            = A[LOW_W-1:2];
    assign a_idx            = A[LOW_W+IDX_W-1:LOW_W];
    assign a_tag            = A[ADDR_W-1:LOW_W+IDX_W];
    assign unused_byte_bits = &{1'b0, A[1:0]};

    assign hit       = valid_q[a_idx] && (tag_q[a_idx] == a_tag);
    assign wr_hit    = (state_q == IDLE) && WriteEnable && hit;
    assign rd_hit    = (state_q == IDLE) && ReadEnable && !WriteEnable && hit;
    assign miss      = (state_q == IDLE) && (ReadEnable || WriteEnable) && !hit;
    assign wb_done   = (state_q == WRITEBACK) && MemReady;
    assign fill_done = (state_q == FILL) && MemReady;

    // NOTE: every output and state_d gets a default before the case, so no path infers a latch.
    always_comb begin
        state_d    = state_q;
        Value      = '0;
        AMem       = '0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        MemWLine   = '0;
        CacheStall = 1'b0;
        case (state_q)
            IDLE: begin
                if (rd_hit) Value = data_q[a_idx][a_off];
                if (miss) begin
                    CacheStall = 1'b1;
                    state_d    = (valid_q[a_idx] && dirty_q[a_idx]) ? WRITEBACK : FILL;
                end
            end
            WRITEBACK: begin
                CacheStall = 1'b1;
                MemWrite   = 1'b1;
                AMem       = {tag_q[a_idx], a_idx, {LOW_W{1'b0}}};
                MemWLine   = data_q[a_idx];
                if (MemReady) state_d = FILL;
            end
            FILL: begin
                CacheStall = 1'b1;
                MemRead    = 1'b1;
                AMem       = {a_tag, a_idx, {LOW_W{1'b0}}};
                if (MemReady) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            if (wr_hit)  dirty_q[a_idx] <= 1'b1;
            if (wb_done) dirty_q[a_idx] <= 1'b0;
            if (fill_done) begin
                valid_q[a_idx] <= 1'b1;
                dirty_q[a_idx] <= 1'b0;
            end
        end
    end

    // NOTE: tag/data arrays have no reset (valid_q qualifies them); writes are still blocked during rst
    // so an abandoned fill never lands in the array.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (wr_hit) data_q[a_idx][a_off] <= WData;
            if (fill_done) begin
                data_q[a_idx] <= MemLine;
                tag_q[a_idx]  <= a_tag;
            end
        end
    end

`ifdef DCACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (rd_hit || wr_hit) hit_cnt_q  <= hit_cnt_q + 32'd1;
            if (miss)             miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign HitCount  = hit_cnt_q;
    assign MissCount = miss_cnt_q;
`else
    assign HitCount  = '0;
    assign MissCount = '0;
`endif
endmodule

// File: tb/tb_dcache_wb.sv
// Directed scoreboard bench for dcache_wb: fills, hits, write-back eviction, reset abort, counters.
// Counter expectations follow DCACHE_PERF_CNT_EN.
module tb_dcache_wb;
    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  A;
    logic         ReadEnable, WriteEnable;
    logic [31:0]  WData;
    logic [127:0] MemLine;
    logic         MemReady;
    logic [31:0]  Value, AMem;
    logic         MemRead, MemWrite, CacheStall;
    logic [127:0] MemWLine;
    logic [31:0]  HitCount, MissCount;

`ifdef DCACHE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] sb [$];

    logic [127:0] line_10  = {32'hAAAA0004, 32'hAAAA0003, 32'hAAAA0002, 32'hAAAA0001};
    logic [127:0] line_110 = {32'hBBBB0004, 32'hBBBB0003, 32'hBBBB0002, 32'hBBBB0001};
    logic [127:0] line_wb;

    dcache_wb dut (
        .clk(clk), .rst(rst), .A(A), .ReadEnable(ReadEnable), .WriteEnable(WriteEnable),
        .WData(WData), .MemLine(MemLine), .MemReady(MemReady), .Value(Value), .AMem(AMem),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemWLine(MemWLine), .CacheStall(CacheStall),
        .HitCount(HitCount), .MissCount(MissCount)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic wait_unstalled(input string tag);
        int n = 0;
        while (CacheStall === 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_unstalled"}, CacheStall, 1'b0);
    endtask

    task automatic pop_value(input string tag);
        logic [31:0] exp;
        check({tag, "_sb_entry"}, sb.size() != 0, 1'b1);
        exp = (sb.size() != 0) ? sb.pop_front() : 32'hx;
        check(tag, Value, exp);
    endtask

    task automatic serve(input logic [127:0] line);
        MemLine  = line;
        MemReady = 1'b1;
        tick();
        MemReady = 1'b0;
        MemLine  = '0;
    endtask

    initial begin
        rst = 1'b1; A = '0; ReadEnable = 1'b0; WriteEnable = 1'b0;
        WData = '0; MemLine = '0; MemReady = 1'b0;
        line_wb = line_10;
        line_wb[63:32] = 32'hDEADBEEF;
        tick(); tick();
        rst = 1'b0;
        sample();
        check("rst_memread",   MemRead,    1'b0);
        check("rst_memwrite",  MemWrite,   1'b0);
        check("rst_stall",     CacheStall, 1'b0);
        check("rst_value",     Value,      32'h0);
        check("rst_amem",      AMem,       32'h0);
        check("rst_hitcount",  HitCount,   32'h0);
        check("rst_misscount", MissCount,  32'h0);

        // Cold read miss at 0x10, fill, replay
        A = 32'h10; ReadEnable = 1'b1; sb.push_back(32'hAAAA0001);
        #1;
        check("cold_miss_stall",    CacheStall, 1'b1);
        check("cold_miss_idle_mrd", MemRead,    1'b0);
        tick(); sample();
        check("fill_memread",  MemRead,    1'b1);
        check("fill_amem",     AMem,       32'h10);
        check("fill_memwrite", MemWrite,   1'b0);
        check("fill_stall",    CacheStall, 1'b1);
        serve(line_10);
        sample();
        wait_unstalled("fill_done");
        pop_value("fill_replay_value");
        check("idle_memread", MemRead, 1'b0);
        tick(); ReadEnable = 1'b0;

        // Three read hits on the other words of the line
        for (int k = 1; k < 4; k++) begin
            A = 32'h10 + 32'(4 * k); ReadEnable = 1'b1;
            sb.push_back(line_10[32*k +: 32]);
            sample();
            check("read_hit_stall", CacheStall, 1'b0);
            pop_value("read_hit_value");
            check("read_hit_memread", MemRead, 1'b0);
            tick(); ReadEnable = 1'b0;
        end
        sample();
        check("cnt_hits",   HitCount,  PERF ? 32'd4 : 32'd0);
        check("cnt_misses", MissCount, PERF ? 32'd1 : 32'd0);

        // Write hit with both enables set: write wins, no load data
        A = 32'h14; WriteEnable = 1'b1; ReadEnable = 1'b1; WData = 32'hDEADBEEF;
        #1;
        check("wr_hit_stall",    CacheStall, 1'b0);
        check("wr_both_value",   Value,      32'h0);
        check("wr_hit_memwrite", MemWrite,   1'b0);
        tick(); WriteEnable = 1'b0; ReadEnable = 1'b0;
        A = 32'h14; ReadEnable = 1'b1; sb.push_back(32'hDEADBEEF);
        sample();
        check("rd_after_wr_stall", CacheStall, 1'b0);
        pop_value("rd_after_wr_value");
        check("rd_after_wr_mrd", MemRead,  1'b0);
        check("rd_after_wr_mwr", MemWrite, 1'b0);
        tick(); ReadEnable = 1'b0;

        // Conflict miss on dirty index 1: writeback then fill
        A = 32'h110; ReadEnable = 1'b1; sb.push_back(32'hBBBB0001);
        sample();
        check("conflict_stall",     CacheStall, 1'b1);
        check("conflict_idle_mwr",  MemWrite,   1'b0);
        tick(); sample();
        check("wb_memwrite", MemWrite,   1'b1);
        check("wb_memread",  MemRead,    1'b0);
        check("wb_amem",     AMem,       32'h10);
        check("wb_line",     MemWLine,   line_wb);
        check("wb_stall",    CacheStall, 1'b1);
        serve('0);
        sample();
        check("wb_fill_memread",  MemRead,  1'b1);
        check("wb_fill_memwrite", MemWrite, 1'b0);
        check("wb_fill_amem",     AMem,     32'h110);
        serve(line_110);
        sample();
        wait_unstalled("wb_fill_done");
        pop_value("wb_fill_value");
        tick(); ReadEnable = 1'b0;

        // Clean victim: straight to fill, written-back data returns
        A = 32'h14; ReadEnable = 1'b1; sb.push_back(32'hDEADBEEF);
        sample();
        check("clean_miss_stall", CacheStall, 1'b1);
        tick(); sample();
        check("clean_no_wb",   MemWrite, 1'b0);
        check("clean_memread", MemRead,  1'b1);
        check("clean_amem",    AMem,     32'h10);
        serve(line_wb);
        sample();
        wait_unstalled("clean_fill");
        pop_value("clean_fill_value");
        tick(); ReadEnable = 1'b0;

        // Reset during FILL abandons the transaction
        A = 32'h150; ReadEnable = 1'b1;
        tick(); sample();
        check("abort_fill_memread", MemRead, 1'b1);
        check("abort_fill_amem",    AMem,    32'h150);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sample();
        check("abort_memread",   MemRead,    1'b0);
        check("abort_memwrite",  MemWrite,   1'b0);
        check("abort_stall",     CacheStall, 1'b1);
        check("abort_hitcount",  HitCount,   32'h0);
        check("abort_misscount", MissCount,  32'h0);
        A = 32'h10; sb.push_back(32'hAAAA0001);
        #1;
        check("post_rst_miss", CacheStall, 1'b1);
        tick(); sample();
        check("post_rst_memread", MemRead, 1'b1);
        check("post_rst_amem",    AMem,    32'h10);
        serve(line_wb);
        sample();
        wait_unstalled("post_rst_fill");
        pop_value("post_rst_value");
        tick(); ReadEnable = 1'b0;
        sample();
        check("final_hits",   HitCount,  PERF ? 32'd1 : 32'd0);
        check("final_misses", MissCount, PERF ? 32'd1 : 32'd0);
        check("sb_drained",   sb.size(), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
